// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the MIPS execute stage.
// A mult/div runs for a fixed number of cycles; mthi/mtlo write in a single cycle.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbg_state
);

  // Handshake: start is a one-cycle strobe, honoured only while busy is low
  // and cancel is low; a caller must hold off HI/LO users while busy or start.

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       opq_q, opq_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic accept;
  logic is_mul;
  logic is_div;
  logic last_cycle;

  always_comb begin
    accept     = (state_q == S_IDLE) && start && !cancel;
    is_mul     = (op[2:1] == 2'b00);
    is_div     = (op[2:1] == 2'b01);
    last_cycle = (cnt_q == CW'(1));
  end

  // Result datapath, evaluated from the latched operands
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               div_signed, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    a_ext = opq_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext = opq_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;

    // Magnitude divide; most-negative / -1 falls out as most-negative, rem 0
    div_signed = !opq_q[0];
    a_neg      = div_signed && a_q[WIDTH-1];
    b_neg      = div_signed && b_q[WIDTH-1];
    a_mag      = a_neg ? -a_q : a_q;
    b_mag      = b_neg ? -b_q : b_q;
    div_zero   = (b_q == '0);
    b_safe     = div_zero ? WIDTH'(1) : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;

    if (opq_q[1]) begin
      res_hi = div_zero ? a_q : rem;
      res_lo = div_zero ? {WIDTH{1'b1}} : quot;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (is_mul || is_div)) state_d = S_RUN;
      S_RUN:  if (cancel || last_cycle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q == S_RUN);
    dbg_state = state_q;
    hi        = hi_q;
    lo        = lo_q;
  end

  // Operand latch, down-counter and HI/LO update
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    opq_d = opq_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept) begin
      if (is_mul || is_div) begin
        a_d   = a;
        b_d   = b;
        opq_d = op[1:0];
        cnt_d = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (op == OP_MTHI) begin
        hi_d = a;
      end else if (op == OP_MTLO) begin
        lo_d = a;
      end
    end else if (state_q == S_RUN) begin
      if (cancel) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (last_cycle) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      opq_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      opq_q <= opq_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios plus random traffic against an
// edge-numbered behavioural model of HI/LO and busy.
module tb_md_unit;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {hi, lo} for a mult/div
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint p;
    int     q;
    int     r;
    logic [63:0] res;
    res = '0;
    case (o)
      3'd0: begin
        p   = longint'($signed(x)) * longint'($signed(y));
        res = p;
      end
      3'd1: res = {32'h0, x} * {32'h0, y};
      3'd2: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q   = $signed(x) / $signed(y);
          r   = $signed(x) % $signed(y);
          res = {r, q};
        end
      end
      3'd3: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: an op accepted at edge e commits at edge e+LAT unless cancelled
  logic        m_busy;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_res;
  int          m_edge = 0;
  int          m_done = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_edge <= m_edge + 1;
      if (m_busy) begin
        if (cancel) m_busy <= 1'b0;
        else if (m_edge == m_done) begin
          m_busy <= 1'b0;
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
        end
      end else if (start && !cancel) begin
        case (op)
          3'd0, 3'd1: begin
            m_busy <= 1'b1;
            m_done <= m_edge + ML;
            m_res  <= ref_result(op, a, b);
          end
          3'd2, 3'd3: begin
            m_busy <= 1'b1;
            m_done <= m_edge + DL;
            m_res  <= ref_result(op, a, b);
          end
          3'd4: m_hi <= a;
          3'd5: m_lo <= a;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #2;
    if (chk_en && !reset) begin
      check("busy", busy, m_busy);
      check("dbg_state", dbg_state, m_busy);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       output int busy_cycles);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(negedge clk);
    start       = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic expect_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_model_hi"}, m_hi, eh);
    check({name, "_model_lo"}, m_lo, el);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 15);
      4: v = -$urandom_range(1, 15);
      default: v = $urandom();
    endcase
    return v;
  endfunction

  int cyc;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = '0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, cyc);
    check("mult_busy_cycles", cyc, ML);
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    expect_hl("multu", 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(3'd5, 32'h1234_5678, 32'h0, cyc);
    check("mtlo_busy_cycles", cyc, 0);
    expect_hl("mtlo", 32'hFFFF_FFFE, 32'h1234_5678);

    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_busy_cycles", cyc, DL);
    expect_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(3'd3, 32'd7, 32'd2, cyc);
    expect_hl("divu", 32'd1, 32'd3);
    do_op(3'd3, 32'd5, 32'd0, cyc);
    expect_hl("divu_zero", 32'd5, 32'hFFFF_FFFF);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    expect_hl("div_ovf", 32'd0, 32'h8000_0000);

    // Ignored start during RUN, then cancel on the third RUN edge
    do_op(3'd4, 32'hA, 32'h0, cyc);
    do_op(3'd5, 32'hB, 32'h0, cyc);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    op = 3'd4; a = 32'h55;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("run_busy", busy, 1);
    check("run_hi_kept", hi, 32'hA);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    expect_hl("cancel", 32'hA, 32'hB);
    do_op(3'd1, 32'd3, 32'd4, cyc);
    check("multu_after_cancel_cycles", cyc, ML);
    expect_hl("multu_after_cancel", 32'd0, 32'd12);

    // Asynchronous reset in the fourth divide cycle
    do_op(3'd4, 32'hDEAD, 32'h0, cyc);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_hi", hi, 32'hDEAD);
    #1 reset = 1'b1;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_hi", hi, 0);
    check("async_reset_lo", lo, 0);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    check("no_late_commit_busy", busy, 0);
    expect_hl("no_late_commit", 32'd0, 32'd0);

    // Random traffic, including starts during RUN and stray cancels
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      a      = pick();
      b      = pick();
      cancel = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    repeat (DL + 5) @(negedge clk);
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers for the execute stage of the five-stage MIPS pipeline. It accepts one operation per start pulse and runs multiplies and divides for a fixed, parameterised number of cycles, holding `busy` high meanwhile. The hazard unit stalls the D stage on any HI/LO-dependent instruction while `busy` or `start` is high. It also supports single-cycle HI/LO writes and an abort input for later exception and flush support.

## Interface
- `WIDTH`, 32: operand and HI/LO width in bits.
- `MULT_LAT`, 5: cycles from multiply acceptance to result commit; must be ≥1.
- `DIV_LAT`, 10: cycles from divide acceptance to result commit; must be ≥1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request strobe, sampled at the rising edge.
- `op` input 3: operation select.
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
  - 110 and 111 are no-ops.
- `a` input WIDTH: rs operand (dividend, multiplicand, or mthi/mtlo data).
- `b` input WIDTH: rt operand (divisor, multiplier).
- `cancel` input 1: abort any in-flight mult/div.
- `busy` output 1: a mult/div is in flight.
- `hi` output WIDTH: HI register, registered.
- `lo` output WIDTH: LO register, registered.

## Operation
- Two states.
  - IDLE: `busy`=0.
  - RUN: `busy`=1; holds the latched operands, latched op, and a down-counter.
- IDLE + `start` + mult/multu:
  - Latch `a`, `b` and `op`.
  - Load counter with `MULT_LAT`; go to RUN.
- IDLE + `start` + div/divu:
  - Same as multiply, but load counter with `DIV_LAT`.
- IDLE + `start` + mthi: `hi` ← `a` at that edge; stay IDLE; `lo` unchanged.
- IDLE + `start` + mtlo: `lo` ← `a` at that edge; stay IDLE; `hi` unchanged.
- RUN, each edge:
  - Decrement the counter.
  - On the edge where the counter goes 1→0, commit the result to `hi`/`lo` and return to IDLE.
- `start` while in RUN is ignored entirely, including mthi/mtlo. Upstream must hold the instruction, which the stall guarantees.
- `cancel` in RUN:
  - Return to IDLE at that edge; `hi`/`lo` keep their pre-operation values.
  - `cancel` has priority over a same-edge commit.
  - `cancel` in IDLE has no effect.
  - `cancel` together with `start` in IDLE: the start is dropped.
- Multiply:
  - Full 2·WIDTH-bit product; `hi` = upper WIDTH bits, `lo` = lower WIDTH bits.
  - mult is signed×signed; multu is unsigned×unsigned.
- Divide:
  - `lo` = quotient truncated toward zero; `hi` = remainder, with the sign of the dividend.
  - div is signed; divu is unsigned.
- Divide by zero (any sign): `lo` = all ones, `hi` = dividend.
- Signed overflow (most-negative ÷ −1): `lo` = most-negative value, `hi` = 0.
- Implementation freedom: the result may be computed iteratively or combinationally from the latched operands. Only the commit edge is visible; `hi`/`lo` must not change before it.

## Timing
- Reset (asynchronous, immediate):
  - `busy`=0, `hi`=0, `lo`=0, counter=0, state IDLE.
  - Reset mid-operation discards the in-flight result.
- Mult/div accepted at edge k:
  - `busy`=1 after edge k.
  - `hi`/`lo` updated and `busy`=0 after edge k+LAT.
  - `busy` is therefore high for exactly LAT cycles.
- Back-to-back operations:
  - A new `start` is accepted at edge k+LAT + 1 or later.
  - At edge k+LAT itself `busy` is still high, so `start` is ignored.
- mthi/mtlo accepted at edge k: value visible after edge k; `busy` never asserts.
- `cancel` sampled at edge j (k < j ≤ k+LAT): `busy`=0 after edge j; no HI/LO change.
- Outputs are purely registered; no combinational path from inputs to outputs.

## Test plan
- **mult, signed × signed:** reset, then mult `a`=0xFFFFFFFD (−3), `b`=7.
  - `busy`=1 for exactly 5 cycles.
  - Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `busy`=0.
- **multu, then mthi/mtlo:** multu 0xFFFFFFFF × 0xFFFFFFFF gives `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - Then mtlo 0x12345678 gives `lo`=0x12345678 one edge later, `hi` unchanged, `busy` never high.
- **div/divu signs:** div −7 / 2 gives `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF after 10 cycles.
  - divu 7 / 2 gives `lo`=3, `hi`=1.
- **Divide corner cases:**
  - divu 5 / 0 gives `lo`=0xFFFFFFFF, `hi`=5.
  - div 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- **Ignored start and cancel:** set `hi`=0xA, `lo`=0xB.
  - Start mult 3×4, then assert mthi 0x55 during RUN: ignored.
  - Assert `cancel` at the 3rd cycle of RUN: `busy`=0 next edge, `hi`=0xA, `lo`=0xB.
  - A new multu 3×4 is then accepted and gives `lo`=12, `hi`=0.
- **Asynchronous reset mid-divide:** raise `reset` between edges during divide cycle 4.
  - `busy`, `hi` and `lo` go to 0 immediately, without waiting for a clock edge.
  - After release, no late commit occurs.
